ex_mem_stage: RTL and testbench
===============================

EX_MEM_STAGE -- requirements
Module: ex_mem_stage

Interface
REQ-001 The block SHALL provide these ports (clock and reset first):
- clk  in  1  sole clock, all state on rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- in_valid  in  1  execute-side result valid
- in_ready  out  1  stage can accept this cycle
- alu_out  in  64  ALU result (sum/logic/shift)
- carry_out  in  1  ALU adder carry-out
- zero  in  1  ALU sum == 0
- a_sign, b_sign  in  1 each  bit 63 of ALU operands A and B
- pc  in  64  instruction PC
- imm  in  64  sign-extended immediate
- funct3  in  3  branch condition / SLT select
- is_branch, is_jal, is_jalr, is_slt, is_sltu  in  1 each  op class, at most one set
- rd  in  5  destination register
- reg_write, mem_read, mem_write  in  1 each  control forwarded to memory stage
- store_data  in  64  rs2 value for stores
- flush  in  1  kill the held entry
- out_valid  out  1  entry held
- out_ready  in  1  memory stage accepts
- out_result, out_store_data  out  64 each  registered writeback/address value and store data
- out_rd  out  5; out_reg_write, out_mem_read, out_mem_write  out  1 each
- redirect  out  1  one-cycle taken-control-transfer pulse
- redirect_pc  out  64  fetch target, valid while redirect=1
- taken_count  out  32  accepted taken branches/jumps, saturating

Function
REQ-002 Transfer in when in_valid && in_ready; transfer out when out_valid && out_ready.
REQ-003 in_ready SHALL equal (!out_valid || out_ready) && !flush, combinationally.
REQ-004 Simultaneous in/out transfer SHALL replace the entry in one cycle, out_valid staying 1.
REQ-005 Out transfer without in transfer SHALL clear out_valid next cycle; held fields unchanged.
REQ-006 While out_valid && !out_ready, all out_* SHALL hold stable.
REQ-007 flush=1 SHALL clear out_valid next edge, override any in transfer, and suppress redirect.
REQ-008 lt_u SHALL be !carry_out; lt_s SHALL be a_sign when a_sign != b_sign, else alu_out[63].
REQ-009 Branch taken per funct3: 000 zero; 001 !zero; 100 lt_s; 101 !lt_s; 110 lt_u; 111 !lt_u; 010/011 never.
REQ-010 Captured out_result: is_slt -> {63'b0,lt_s}; is_sltu -> {63'b0,lt_u}; is_jal/is_jalr -> pc+4 (mod 2^64); otherwise alu_out.
REQ-011 Target: branch/jal -> pc+imm (mod 2^64); jalr -> alu_out with bit 0 forced 0.
REQ-012 On an in transfer that is taken (branch taken, or any jal/jalr), redirect SHALL be 1 exactly the next cycle with redirect_pc = target; else 0 the next cycle.
REQ-013 redirect SHALL be 1 for one cycle only, regardless of out_ready stall.
REQ-014 taken_count SHALL increment by 1 on each cycle redirect is 1, saturating at 32'hFFFF_FFFF.
REQ-015 Control outputs (out_reg_write, out_mem_read, out_mem_write) SHALL read 0 whenever out_valid=0.
REQ-016 Latency in -> out SHALL be exactly one cycle with out_ready=1; throughput one per cycle.
REQ-017 Multiple op-class bits set: behaviour undefined; bench SHALL not drive it.

Reset
REQ-018 rst_n=0 SHALL asynchronously force out_valid=0, redirect=0, taken_count=0, out_result=0, out_store_data=0, redirect_pc=0, out_rd=0, all control outputs 0.
REQ-019 After rst_n rises, first in transfer SHALL be possible the first edge.
REQ-020 Reset asserted mid-stall SHALL drop the held entry and any pending redirect immediately, without clock.

Verification
REQ-021 BEQ: alu_out=0, zero=1, funct3=000, pc=0x1000, imm=0x40 -> next cycle redirect=1, redirect_pc=0x1040, taken_count=1.
REQ-022 BLTU: carry_out=0, funct3=110 -> taken; carry_out=1 -> redirect=0 next cycle.
REQ-023 SLT: a_sign=1, b_sign=0, alu_out[63]=0, is_slt=1 -> out_result=1; a_sign=b_sign=0, alu_out[63]=1 -> 1; alu_out[63]=0 -> 0.
REQ-024 JALR: pc=0x2000, alu_out=0x3007 -> out_result=0x2004, redirect_pc=0x3006.
REQ-025 Backpressure: out_ready=0 for 3 cycles with entry held -> in_ready=0, outputs stable, redirect pulsed once; out_ready=1 with new in_valid -> entry replaced same edge.
REQ-026 Flush and reset: flush with in_valid=1 on a taken branch -> out_valid=0, redirect=0; rst_n low mid-stall -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/ex_mem_stage.sv
// Execute/memory pipeline register with branch resolution.
// Holds one execute result for the memory stage behind a valid/ready
// handshake. Branch conditions, SLT/SLTU results and link values are
// resolved from the ALU flags on capture. A taken control transfer raises
// a single-cycle redirect pulse toward fetch and bumps a saturating counter.
module ex_mem_stage (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [63:0] alu_out,
   input  logic        carry_out,
   input  logic        zero,
   input  logic        a_sign,
   input  logic        b_sign,
   input  logic [63:0] pc,
   input  logic [63:0] imm,
   input  logic [2:0]  funct3,
   input  logic        is_branch,
   input  logic        is_jal,
   input  logic        is_jalr,
   input  logic        is_slt,
   input  logic        is_sltu,
   input  logic [4:0]  rd,
   input  logic        reg_write,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic [63:0] store_data,
   input  logic        flush,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [63:0] out_result,
   output logic [63:0] out_store_data,
   output logic [4:0]  out_rd,
   output logic        out_reg_write,
   output logic        out_mem_read,
   output logic        out_mem_write,
   output logic        redirect,
   output logic [63:0] redirect_pc,
   output logic [31:0] taken_count
);

   logic        valid_q,       valid_d;
   logic [63:0] result_q,      result_d;
   logic [63:0] store_data_q,  store_data_d;
   logic [4:0]  rd_q,          rd_d;
   logic        reg_write_q,   reg_write_d;
   logic        mem_read_q,    mem_read_d;
   logic        mem_write_q,   mem_write_d;
   logic        redirect_q,    redirect_d;
   logic [63:0] redirect_pc_q, redirect_pc_d;
   logic [31:0] taken_count_q, taken_count_d;

   logic        in_fire;
   logic        out_fire;
   logic        lt_u;
   logic        lt_s;
   logic        branch_cond;
   logic        taken;
   logic [63:0] link_pc;
   logic [63:0] target;
   logic [63:0] result_new;

   // Handshake: a flush blocks acceptance so it always wins over a new entry.
   always_comb begin
      in_ready = (!valid_q || out_ready) && !flush;
      in_fire  = in_valid && in_ready;
      out_fire = valid_q && out_ready;
   end

   // Resolve comparisons, branch outcome, writeback value and fetch target.
   always_comb begin
      // carry_out=0 on A-B means a borrow, i.e. A < B unsigned.
      lt_u = !carry_out;
      // With differing signs the negative operand is smaller; otherwise the
      // difference cannot overflow and its sign bit decides.
      lt_s = (a_sign != b_sign) ? a_sign : alu_out[63];
      case (funct3)
         3'b000:  branch_cond = zero;
         3'b001:  branch_cond = !zero;
         3'b100:  branch_cond = lt_s;
         3'b101:  branch_cond = !lt_s;
         3'b110:  branch_cond = lt_u;
         3'b111:  branch_cond = !lt_u;
         default: branch_cond = 1'b0;
      endcase
      taken   = (is_branch && branch_cond) || is_jal || is_jalr;
      link_pc = pc + 64'd4;
      if (is_jalr) target = {alu_out[63:1], 1'b0};
      else         target = pc + imm;
      if (is_slt)                 result_new = {63'b0, lt_s};
      else if (is_sltu)           result_new = {63'b0, lt_u};
      else if (is_jal || is_jalr) result_new = link_pc;
      else                        result_new = alu_out;
   end

   // Next-state for the held entry, redirect pulse and taken counter.
   always_comb begin
      valid_d       = valid_q;
      result_d      = result_q;
      store_data_d  = store_data_q;
      rd_d          = rd_q;
      reg_write_d   = reg_write_q;
      mem_read_d    = mem_read_q;
      mem_write_d   = mem_write_q;
      redirect_d    = 1'b0;
      redirect_pc_d = redirect_pc_q;
      taken_count_d = taken_count_q;
      if (flush) begin
         valid_d = 1'b0;
      end else if (in_fire) begin
         valid_d      = 1'b1;
         result_d     = result_new;
         store_data_d = store_data;
         rd_d         = rd;
         reg_write_d  = reg_write;
         mem_read_d   = mem_read;
         mem_write_d  = mem_write;
      end else if (out_fire) begin
         valid_d = 1'b0;
      end
      // Counter moves in the same edge the pulse rises so it already
      // includes the transfer being announced.
      if (in_fire && taken) begin
         redirect_d    = 1'b1;
         redirect_pc_d = target;
         if (taken_count_q != 32'hFFFF_FFFF) taken_count_d = taken_count_q + 32'd1;
      end
   end

   // State registers, cleared asynchronously.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q       <= 1'b0;
         result_q      <= '0;
         store_data_q  <= '0;
         rd_q          <= '0;
         reg_write_q   <= 1'b0;
         mem_read_q    <= 1'b0;
         mem_write_q   <= 1'b0;
         redirect_q    <= 1'b0;
         redirect_pc_q <= '0;
         taken_count_q <= '0;
      end else begin
         valid_q       <= valid_d;
         result_q      <= result_d;
         store_data_q  <= store_data_d;
         rd_q          <= rd_d;
         reg_write_q   <= reg_write_d;
         mem_read_q    <= mem_read_d;
         mem_write_q   <= mem_write_d;
         redirect_q    <= redirect_d;
         redirect_pc_q <= redirect_pc_d;
         taken_count_q <= taken_count_d;
      end
   end

   // Control strobes are qualified so a stale entry never drives memory.
   always_comb begin
      out_valid      = valid_q;
      out_result     = result_q;
      out_store_data = store_data_q;
      out_rd         = rd_q;
      out_reg_write  = valid_q && reg_write_q;
      out_mem_read   = valid_q && mem_read_q;
      out_mem_write  = valid_q && mem_write_q;
      redirect       = redirect_q;
      redirect_pc    = redirect_pc_q;
      taken_count    = taken_count_q;
   end

endmodule

// File: tb/tb_ex_mem_stage.sv
// Scoreboard bench for ex_mem_stage: inputs change on the falling edge,
// expected entries are queued on accepted transfers and compared while held.
module tb_ex_mem_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [63:0] alu_out;
   logic        carry_out, zero, a_sign, b_sign;
   logic [63:0] pc, imm;
   logic [2:0]  funct3;
   logic        is_branch, is_jal, is_jalr, is_slt, is_sltu;
   logic [4:0]  rd;
   logic        reg_write, mem_read, mem_write;
   logic [63:0] store_data;
   logic        flush;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] out_result, out_store_data;
   logic [4:0]  out_rd;
   logic        out_reg_write, out_mem_read, out_mem_write;
   logic        redirect;
   logic [63:0] redirect_pc;
   logic [31:0] taken_count;

   typedef struct {
      logic [63:0] result;
      logic [63:0] sdata;
      logic [4:0]  rd;
      logic [2:0]  ctl;
   } exp_t;

   exp_t        sb[$];
   logic        exp_valid;
   logic [31:0] exp_count;
   int          n_checks = 0;
   int          n_pass   = 0;

   always #5 clk = ~clk;

   ex_mem_stage dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .alu_out(alu_out), .carry_out(carry_out), .zero(zero),
      .a_sign(a_sign), .b_sign(b_sign), .pc(pc), .imm(imm), .funct3(funct3),
      .is_branch(is_branch), .is_jal(is_jal), .is_jalr(is_jalr),
      .is_slt(is_slt), .is_sltu(is_sltu), .rd(rd), .reg_write(reg_write),
      .mem_read(mem_read), .mem_write(mem_write), .store_data(store_data),
      .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
      .out_result(out_result), .out_store_data(out_store_data), .out_rd(out_rd),
      .out_reg_write(out_reg_write), .out_mem_read(out_mem_read),
      .out_mem_write(out_mem_write), .redirect(redirect),
      .redirect_pc(redirect_pc), .taken_count(taken_count)
   );

   // Reference model of one accepted execute result.
   function automatic void model(output exp_t e, output logic tk, output logic [63:0] tgt);
      logic lu, ls, bc;
      lu = !carry_out;
      ls = (a_sign != b_sign) ? a_sign : alu_out[63];
      case (funct3)
         3'b000: bc = zero;
         3'b001: bc = !zero;
         3'b100: bc = ls;
         3'b101: bc = !ls;
         3'b110: bc = lu;
         3'b111: bc = !lu;
         default: bc = 1'b0;
      endcase
      tk = (is_branch && bc) || is_jal || is_jalr;
      tgt = is_jalr ? (alu_out & ~64'd1) : (pc + imm);
      if (is_slt)                 e.result = {63'b0, ls};
      else if (is_sltu)           e.result = {63'b0, lu};
      else if (is_jal || is_jalr) e.result = pc + 64'd4;
      else                        e.result = alu_out;
      e.sdata = store_data;
      e.rd    = rd;
      e.ctl   = {reg_write, mem_read, mem_write};
   endfunction

   task automatic idle_inputs();
      in_valid = 0; alu_out = '0; carry_out = 0; zero = 0; a_sign = 0; b_sign = 0;
      pc = '0; imm = '0; funct3 = 3'b010; is_branch = 0; is_jal = 0; is_jalr = 0;
      is_slt = 0; is_sltu = 0; rd = '0; reg_write = 0; mem_read = 0; mem_write = 0;
      store_data = '0; flush = 0;
   endtask

   // One clock: called on a falling edge with inputs already set, returns on the next one.
   task automatic tick();
      exp_t e, h;
      logic fin, fout, tk, was_valid;
      logic [63:0] tgt;
      #1;
      n_checks++;
      if (in_ready !== ((!exp_valid || out_ready) && !flush))
         $display("FAIL in_ready: got %b want %b", in_ready, (!exp_valid || out_ready) && !flush);
      else n_pass++;
      fin = in_valid && in_ready;
      fout = exp_valid && out_ready;
      was_valid = exp_valid;
      tk = 1'b0; tgt = '0;
      if (fout && sb.size() > 0) begin
         h = sb.pop_front();
         n_checks++;
         if (out_result !== h.result || out_rd !== h.rd || out_store_data !== h.sdata)
            $display("FAIL out_xfer: got res=%h rd=%0d sd=%h want res=%h rd=%0d sd=%h",
                     out_result, out_rd, out_store_data, h.result, h.rd, h.sdata);
         else n_pass++;
      end
      if (flush && !fout && was_valid && sb.size() > 0) void'(sb.pop_front());
      if (fin) begin
         model(e, tk, tgt);
         sb.push_back(e);
      end
      @(posedge clk);
      #1;
      exp_valid = flush ? 1'b0 : fin ? 1'b1 : fout ? 1'b0 : was_valid;
      if (fin && tk && exp_count != 32'hFFFF_FFFF) exp_count = exp_count + 1;
      n_checks++;
      if (out_valid !== exp_valid) $display("FAIL out_valid: got %b want %b", out_valid, exp_valid);
      else n_pass++;
      n_checks++;
      if (redirect !== (fin && tk)) $display("FAIL redirect: got %b want %b", redirect, fin && tk);
      else n_pass++;
      if (fin && tk) begin
         n_checks++;
         if (redirect_pc !== tgt) $display("FAIL redirect_pc: got %h want %h", redirect_pc, tgt);
         else n_pass++;
      end
      n_checks++;
      if (taken_count !== exp_count) $display("FAIL taken_count: got %0d want %0d", taken_count, exp_count);
      else n_pass++;
      if (exp_valid && sb.size() > 0) begin
         h = sb[0];
         n_checks++;
         if (out_result !== h.result || out_rd !== h.rd || out_store_data !== h.sdata ||
             {out_reg_write, out_mem_read, out_mem_write} !== h.ctl)
            $display("FAIL held: got res=%h rd=%0d sd=%h ctl=%b want res=%h rd=%0d sd=%h ctl=%b",
                     out_result, out_rd, out_store_data, {out_reg_write, out_mem_read, out_mem_write},
                     h.result, h.rd, h.sdata, h.ctl);
         else n_pass++;
      end else begin
         n_checks++;
         if ({out_reg_write, out_mem_read, out_mem_write} !== 3'b000)
            $display("FAIL ctl_gate: got %b want 000", {out_reg_write, out_mem_read, out_mem_write});
         else n_pass++;
      end
      @(negedge clk);
   endtask

   task automatic test_reset();
      idle_inputs();
      out_ready = 1;
      rst_n = 0;
      sb.delete(); exp_valid = 0; exp_count = 0;
      repeat (2) @(negedge clk);
      n_checks++;
      if ({out_valid, redirect, out_reg_write, out_mem_read, out_mem_write} !== 5'b0)
         $display("FAIL reset_flags: got %b want 00000",
                  {out_valid, redirect, out_reg_write, out_mem_read, out_mem_write});
      else n_pass++;
      n_checks++;
      if (taken_count !== 32'd0 || out_rd !== 5'd0) $display("FAIL reset_cnt: got cnt=%0d rd=%0d want 0 0", taken_count, out_rd);
      else n_pass++;
      n_checks++;
      if (out_result !== 64'd0 || out_store_data !== 64'd0 || redirect_pc !== 64'd0)
         $display("FAIL reset_data: got res=%h sd=%h rpc=%h want 0", out_result, out_store_data, redirect_pc);
      else n_pass++;
      rst_n = 1;
   endtask

   task automatic test_beq();
      idle_inputs();
      in_valid = 1; is_branch = 1; funct3 = 3'b000; zero = 1; alu_out = '0;
      pc = 64'h1000; imm = 64'h40; rd = 5'd3; store_data = 64'hABCD;
      tick();
      n_checks++;
      if (redirect !== 1'b1 || redirect_pc !== 64'h1040 || taken_count !== 32'd1)
         $display("FAIL beq: got r=%b pc=%h cnt=%0d want 1 1040 1", redirect, redirect_pc, taken_count);
      else n_pass++;
      idle_inputs();
      tick();
   endtask

   task automatic test_bltu();
      idle_inputs();
      in_valid = 1; is_branch = 1; funct3 = 3'b110; carry_out = 0;
      pc = 64'h500; imm = 64'hFFFF_FFFF_FFFF_FFF0;
      tick();
      n_checks++;
      if (redirect !== 1'b1 || redirect_pc !== 64'h4F0)
         $display("FAIL bltu_taken: got r=%b pc=%h want 1 4f0", redirect, redirect_pc);
      else n_pass++;
      carry_out = 1;
      tick();
      n_checks++;
      if (redirect !== 1'b0) $display("FAIL bltu_not: got %b want 0", redirect);
      else n_pass++;
      idle_inputs();
      tick();
   endtask

   task automatic test_slt();
      logic [63:0] want [3];
      want[0] = 64'd1; want[1] = 64'd1; want[2] = 64'd0;
      for (int i = 0; i < 3; i++) begin
         idle_inputs();
         in_valid = 1; is_slt = 1; rd = 5'd7; reg_write = 1;
         case (i)
            0: begin a_sign = 1; b_sign = 0; alu_out = 64'h1; end
            1: begin alu_out = 64'h8000_0000_0000_0000; end
            default: alu_out = 64'h7FFF_0000_0000_0000;
         endcase
         tick();
         n_checks++;
         if (out_result !== want[i]) $display("FAIL slt_%0d: got %h want %h", i, out_result, want[i]);
         else n_pass++;
      end
      idle_inputs();
      tick();
   endtask

   task automatic test_jalr();
      idle_inputs();
      in_valid = 1; is_jalr = 1; pc = 64'h2000; alu_out = 64'h3007; rd = 5'd1; reg_write = 1;
      tick();
      n_checks++;
      if (out_result !== 64'h2004 || redirect_pc !== 64'h3006 || redirect !== 1'b1)
         $display("FAIL jalr: got res=%h rpc=%h r=%b want 2004 3006 1", out_result, redirect_pc, redirect);
      else n_pass++;
      idle_inputs();
      tick();
   endtask

   task automatic test_backpressure();
      int pulses;
      idle_inputs();
      out_ready = 0;
      in_valid = 1; is_jal = 1; pc = 64'h100; imm = 64'h20; rd = 5'd5; reg_write = 1; mem_write = 1;
      store_data = 64'h55;
      tick();
      pulses = redirect ? 1 : 0;
      idle_inputs();
      in_valid = 1; alu_out = 64'hDEAD_BEEF; rd = 5'd9; mem_read = 1;
      for (int i = 0; i < 3; i++) begin
         tick();
         if (redirect) pulses++;
      end
      n_checks++;
      if (pulses !== 1) $display("FAIL bp_pulse: got %0d want 1", pulses);
      else n_pass++;
      n_checks++;
      if (out_result !== 64'h104 || in_ready !== 1'b0) $display("FAIL bp_hold: got res=%h rdy=%b want 104 0", out_result, in_ready);
      else n_pass++;
      out_ready = 1;
      tick();
      n_checks++;
      if (out_result !== 64'hDEAD_BEEF || out_valid !== 1'b1 || out_rd !== 5'd9)
         $display("FAIL bp_replace: got res=%h v=%b rd=%0d want deadbeef 1 9", out_result, out_valid, out_rd);
      else n_pass++;
      idle_inputs();
      tick();
   endtask

   task automatic test_flush();
      idle_inputs();
      out_ready = 0;
      in_valid = 1; alu_out = 64'h77; reg_write = 1;
      tick();
      in_valid = 1; is_branch = 1; funct3 = 3'b001; zero = 0; flush = 1;
      tick();
      n_checks++;
      if (out_valid !== 1'b0 || redirect !== 1'b0) $display("FAIL flush: got v=%b r=%b want 0 0", out_valid, redirect);
      else n_pass++;
      out_ready = 1;
      idle_inputs();
      tick();
   endtask

   task automatic test_reset_mid_stall();
      idle_inputs();
      out_ready = 0;
      in_valid = 1; is_jal = 1; pc = 64'h900; rd = 5'd2; reg_write = 1; store_data = 64'h12;
      tick();
      #2 rst_n = 0;
      #1;
      n_checks++;
      if ({out_valid, redirect, out_reg_write} !== 3'b000 || taken_count !== 32'd0 ||
          out_result !== 64'd0 || out_store_data !== 64'd0 || redirect_pc !== 64'd0 || out_rd !== 5'd0)
         $display("FAIL async_rst: got v=%b r=%b cnt=%0d res=%h rpc=%h want all 0",
                  out_valid, redirect, taken_count, out_result, redirect_pc);
      else n_pass++;
      sb.delete(); exp_valid = 0; exp_count = 0;
      @(negedge clk);
      rst_n = 1;
      out_ready = 1;
      idle_inputs();
      in_valid = 1; alu_out = 64'h31; rd = 5'd4;
      tick();
      n_checks++;
      if (out_valid !== 1'b1 || out_result !== 64'h31) $display("FAIL first_xfer: got v=%b res=%h want 1 31", out_valid, out_result);
      else n_pass++;
      idle_inputs();
      tick();
   endtask

   task automatic test_random();
      for (int i = 0; i < 300; i++) begin
         idle_inputs();
         in_valid   = ($urandom_range(0, 3) != 0);
         out_ready  = ($urandom_range(0, 2) != 0);
         flush      = ($urandom_range(0, 9) == 0);
         alu_out    = {$urandom, $urandom};
         carry_out  = $urandom_range(0, 1);
         zero       = $urandom_range(0, 1);
         a_sign     = $urandom_range(0, 1);
         b_sign     = $urandom_range(0, 1);
         pc         = {$urandom, $urandom};
         imm        = {$urandom, $urandom};
         funct3     = 3'($urandom_range(0, 7));
         rd         = 5'($urandom_range(0, 31));
         reg_write  = $urandom_range(0, 1);
         mem_read   = $urandom_range(0, 1);
         mem_write  = $urandom_range(0, 1);
         store_data = {$urandom, $urandom};
         case ($urandom_range(0, 5))
            1: is_branch = 1;
            2: is_jal = 1;
            3: is_jalr = 1;
            4: is_slt = 1;
            5: is_sltu = 1;
            default: ;
         endcase
         tick();
      end
      idle_inputs();
      out_ready = 1;
      tick();
   endtask

   initial begin
      rst_n = 0;
      out_ready = 1;
      idle_inputs();
      @(negedge clk);
      test_reset();
      test_beq();
      test_bltu();
      test_slt();
      test_jalr();
      test_backpressure();
      test_flush();
      test_reset_mid_stall();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
